// File: rtl/video_timing_rx.sv
// video_timing_rx: pixel-clock video timing receiver.
// Registers DE/HS/VS/RGB, measures line and frame geometry, tracks lock over
// consecutive matching frames and re-emits active pixels with X/Y coordinates
// and start-of-frame / start-of-line markers two cycles after input.
// Optional feature macro: VTRX_POL_DETECT_EN (HS/VS polarity auto-detect).
// Without it, HS and VS are treated as active-high.
//
// Handshake: there is no back-pressure. oDE is a pure valid qualifier; oDATA,
// oX, oY, oSOL and oSOF are meaningful only in cycles where oDE is 1.
module video_timing_rx #(
   parameter int CNT_W       = 12,
   parameter int LOCK_FRAMES = 2
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iDE,
   input  logic             iHS,
   input  logic             iVS,
   input  logic [23:0]      iDATA,
   output logic             oDE,
   output logic [23:0]      oDATA,
   output logic [CNT_W-1:0] oX,
   output logic [CNT_W-1:0] oY,
   output logic             oSOF,
   output logic             oSOL,
   output logic [CNT_W-1:0] oH_TOTAL,
   output logic [CNT_W-1:0] oH_ACTIVE,
   output logic [CNT_W-1:0] oV_TOTAL,
   output logic [CNT_W-1:0] oV_ACTIVE,
   output logic             oLOCKED,
   output logic             oERR,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

   // Stage 1 input registers and previous sync levels
   logic             s1_de, s1_hs, s1_vs;
   logic [23:0]      s1_data;
   logic             p_hs, p_vs;

   // Polarity normalisation (1 = sync is active-low on the wire)
   logic             hs_inv, vs_inv, pol_chg;

   // Measurement counters
   logic [CNT_W-1:0] hcnt, de_cnt, vcnt, act_lines, line_act_max, h_ref;
   logic             line_de, h_valid, frame_bad;

   // Lock tracking
   state_t           state_q, state_d;
   logic [3:0]       match_q, match_d;
   logic [4*CNT_W-1:0] prev_cand;
   logic             prev_valid;
   logic             load_geom, err_d;

   // Combinational per-cycle values
   logic             hs_edge, vs_edge, sat_evt, restart;
   logic [CNT_W-1:0] ht, x_cur, act_cur, act_pix, y_cur, act_max_close;
   logic [CNT_W-1:0] cand_h, cand_v;
   logic             line_de_cur, first_de, hbad_now, frame_bad_close, cand_match;
   logic [4*CNT_W-1:0] cand;

   assign dbg_state = state_q;

   // Capture inputs and remember last cycle's sync levels for edge detection
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         s1_de   <= 1'b0;
         s1_hs   <= 1'b0;
         s1_vs   <= 1'b0;
         s1_data <= '0;
         p_hs    <= 1'b0;
         p_vs    <= 1'b0;
      end else begin
         s1_de   <= iDE;
         s1_hs   <= iHS;
         s1_vs   <= iVS;
         s1_data <= iDATA;
         p_hs    <= s1_hs;
         p_vs    <= s1_vs;
      end
   end

`ifdef VTRX_POL_DETECT_EN
   logic p_de;

   // Sync levels seen at each DE rising edge are the inactive levels
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         p_de   <= 1'b0;
         hs_inv <= 1'b0;
         vs_inv <= 1'b0;
      end else begin
         p_de <= s1_de;
         if (s1_de && !p_de) begin
            hs_inv <= s1_hs;
            vs_inv <= s1_vs;
         end
      end
   end

   assign pol_chg = s1_de && !p_de && ((s1_hs != hs_inv) || (s1_vs != vs_inv));
`else
   assign hs_inv  = 1'b0;
   assign vs_inv  = 1'b0;
   assign pol_chg = 1'b0;
`endif

   // Edge detection, pixel coordinates and frame candidate
   always_comb begin
      hs_edge     = (s1_hs ^ hs_inv) && !(p_hs ^ hs_inv);
      vs_edge     = (s1_vs ^ vs_inv) && !(p_vs ^ vs_inv);
      sat_evt     = !hs_edge && (hcnt == (CNT_MAX - CNT_ONE));
      restart     = sat_evt || pol_chg;
      ht          = hcnt + CNT_ONE;
      // A line closes on the HS edge before the VS edge opens the new frame
      x_cur       = hs_edge ? '0 : de_cnt;
      line_de_cur = hs_edge ? 1'b0 : line_de;
      act_cur     = vs_edge ? '0 : act_lines;
      first_de    = s1_de && !line_de_cur;
      act_pix     = first_de ? (act_cur + CNT_ONE) : act_cur;
      y_cur       = act_pix - CNT_ONE;
      act_max_close = (de_cnt > line_act_max) ? de_cnt : line_act_max;
      hbad_now    = hs_edge && h_valid && (ht != h_ref);
      frame_bad_close = frame_bad || hbad_now;
      cand_h      = h_valid ? h_ref : ht;
      cand_v      = vcnt + {{(CNT_W-1){1'b0}}, hs_edge};
      cand        = {cand_h, act_max_close, cand_v, act_lines};
      cand_match  = prev_valid && (cand == prev_cand);
   end

   // Line/frame measurement counters
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         hcnt         <= '0;
         de_cnt       <= '0;
         vcnt         <= '0;
         act_lines    <= '0;
         line_act_max <= '0;
         h_ref        <= '0;
         line_de      <= 1'b0;
         h_valid      <= 1'b0;
         frame_bad    <= 1'b0;
      end else if (restart) begin
         hcnt         <= sat_evt ? CNT_MAX : '0;
         de_cnt       <= '0;
         vcnt         <= '0;
         act_lines    <= '0;
         line_act_max <= '0;
         h_ref        <= '0;
         line_de      <= 1'b0;
         h_valid      <= 1'b0;
         frame_bad    <= 1'b0;
      end else begin
         hcnt      <= hs_edge ? '0 : ((hcnt == CNT_MAX) ? CNT_MAX : (hcnt + CNT_ONE));
         de_cnt    <= s1_de ? (x_cur + CNT_ONE) : x_cur;
         line_de   <= line_de_cur || s1_de;
         act_lines <= act_pix;
         if (vs_edge) begin
            vcnt         <= '0;
            line_act_max <= '0;
            h_valid      <= 1'b0;
            frame_bad    <= 1'b0;
         end else if (hs_edge) begin
            vcnt         <= vcnt + CNT_ONE;
            line_act_max <= act_max_close;
            frame_bad    <= frame_bad_close;
            if (!h_valid) begin
               h_ref   <= ht;
               h_valid <= 1'b1;
            end
         end
      end
   end

   // Lock FSM next-state: evaluated on VS edges, overridden by restarts
   always_comb begin
      state_d   = state_q;
      match_d   = match_q;
      load_geom = 1'b0;
      err_d     = 1'b0;
      if (restart) begin
         state_d = ST_UNLOCKED;
         match_d = '0;
         err_d   = (state_q == ST_LOCKED);
      end else if (vs_edge) begin
         case (state_q)
            ST_UNLOCKED: begin
               state_d = ST_ACQUIRE;
               match_d = '0;
            end
            ST_ACQUIRE: begin
               if (cand_match && !frame_bad_close) begin
                  match_d = match_q + 4'd1;
                  if ((match_q + 4'd1) == LOCK_N) begin
                     state_d   = ST_LOCKED;
                     load_geom = 1'b1;
                  end
               end else begin
                  match_d = '0;
               end
            end
            ST_LOCKED: begin
               if (!cand_match || frame_bad_close) begin
                  state_d = ST_ACQUIRE;
                  match_d = '0;
                  err_d   = 1'b1;
               end
            end
            default: begin
               state_d = ST_UNLOCKED;
               match_d = '0;
            end
         endcase
      end
   end

   // Lock FSM state, previous candidate and registered lock outputs
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q    <= ST_UNLOCKED;
         match_q    <= '0;
         prev_cand  <= '0;
         prev_valid <= 1'b0;
         oLOCKED    <= 1'b0;
         oERR       <= 1'b0;
         oH_TOTAL   <= '0;
         oH_ACTIVE  <= '0;
         oV_TOTAL   <= '0;
         oV_ACTIVE  <= '0;
      end else begin
         state_q <= state_d;
         match_q <= match_d;
         oLOCKED <= (state_d == ST_LOCKED);
         oERR    <= err_d;
         if (restart) begin
            prev_valid <= 1'b0;
         end else if (vs_edge) begin
            prev_cand  <= cand;
            // The frame closed when leaving UNLOCKED is partial; never compare it
            prev_valid <= (state_q != ST_UNLOCKED);
         end
         if (load_geom) begin
            oH_TOTAL  <= cand_h;
            oH_ACTIVE <= act_max_close;
            oV_TOTAL  <= cand_v;
            oV_ACTIVE <= act_lines;
         end
      end
   end

   // Stage 2: re-emit pixel with coordinates and markers
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oDE   <= 1'b0;
         oDATA <= '0;
         oX    <= '0;
         oY    <= '0;
         oSOL  <= 1'b0;
         oSOF  <= 1'b0;
      end else begin
         oDE   <= s1_de;
         oDATA <= s1_data;
         oX    <= x_cur;
         oY    <= y_cur;
         oSOL  <= s1_de && (x_cur == '0);
         oSOF  <= s1_de && (x_cur == '0) && (y_cur == '0) && (state_q == ST_LOCKED);
      end
   end

endmodule

// File: tb/tb_video_timing_rx.sv
// tb_video_timing_rx: directed stimulus for video_timing_rx with a pixel
// scoreboard. Frame geometry: 20 clocks/line (HS clocks 0-1, DE clocks 4-15),
// 10 lines/frame (VS lines 0-1, active lines 3-8).
module tb_video_timing_rx;

  localparam int CNT_W = 12;
  localparam int W     = 50;

  // Clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             iRST;
  logic             iDE, iHS, iVS;
  logic [23:0]      iDATA;
  logic             oDE, oSOF, oSOL, oLOCKED, oERR;
  logic [23:0]      oDATA;
  logic [CNT_W-1:0] oX, oY, oH_TOTAL, oH_ACTIVE, oV_TOTAL, oV_ACTIVE;
  logic [1:0]       dbg_state;

  video_timing_rx #(.CNT_W(CNT_W), .LOCK_FRAMES(2)) dut (
    .iCLK(clk), .iRST(iRST), .iDE(iDE), .iHS(iHS), .iVS(iVS), .iDATA(iDATA),
    .oDE(oDE), .oDATA(oDATA), .oX(oX), .oY(oY), .oSOF(oSOF), .oSOL(oSOL),
    .oH_TOTAL(oH_TOTAL), .oH_ACTIVE(oH_ACTIVE), .oV_TOTAL(oV_TOTAL),
    .oV_ACTIVE(oV_ACTIVE), .oLOCKED(oLOCKED), .oERR(oERR), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int lock_rise_cyc = 0;
  int last_drive_cyc = 0;
  int fr_id = 0;
  bit mon_en = 1'b1;
  bit push_en = 1'b1;
  logic prev_locked = 1'b0;
  logic prev_err = 1'b0;
  logic [W-1:0] exp_q[$];

  localparam logic [47:0] GEOM = {12'd20, 12'd12, 12'd10, 12'd6};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Driver: inputs change 1 time unit after the rising edge
  task automatic drive(input logic de, input logic hs, input logic vs, input logic [23:0] d);
    @(posedge clk);
    #1;
    iDE = de; iHS = hs; iVS = vs; iDATA = d;
    last_drive_cyc = cyc;
  endtask

  // Scoreboard monitor: pixels, oERR pulses and lock rise time
  task automatic monitor_loop();
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(negedge clk);
      if (mon_en && oDE) begin
        a = {oSOF, oSOL, oX, oY, oDATA};
        if (exp_q.size() == 0) begin
          check("pixel_unexpected", 64'(a), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("pixel", 64'(a), 64'(e));
        end
      end
      if (prev_err) check("err_width", 64'(oERR), 64'd0);
      if (oERR) begin
        check("err_lock_fall", 64'({prev_locked, oLOCKED}), 64'd2);
        err_cnt++;
        err_cyc = cyc;
      end
      if (oLOCKED && !prev_locked) lock_rise_cyc = cyc;
      prev_locked = oLOCKED;
      prev_err = oERR;
    end
  endtask

  // One full frame; optional long line and optional mid-line reset
  task automatic run_frame(input int bad_line, input bit sof_en, input int rst_line,
                           output int vs_cyc);
    int len, x, y;
    logic de;
    logic [23:0] d;
    fr_id++;
    mon_en = 1'b1;
    push_en = 1'b1;
    vs_cyc = 0;
    for (int ln = 0; ln < 10; ln++) begin
      len = (ln == bad_line) ? 21 : 20;
      for (int c = 0; c < len; c++) begin
        x = c - 4;
        y = ln - 3;
        de = (ln >= 3 && ln <= 8 && c >= 4 && c <= 15);
        d = (x == 0 && y == 0) ? 24'hA5A5A5 : {8'(fr_id), 4'(y), 12'(x)};
        drive(de, c < 2, ln < 2, d);
        if (ln == 0 && c == 0) vs_cyc = last_drive_cyc;
        if (de && push_en)
          exp_q.push_back({(sof_en && x == 0 && y == 0), (x == 0), 12'(x), 12'(y), d});
        if (ln == rst_line && c == 8) begin
          check("locked_before_rst", 64'(oLOCKED), 64'd1);
          #1 iRST = 1'b1;
          mon_en = 1'b0;
          push_en = 1'b0;
          exp_q.delete();
          #1;
          check("rst_async_ctl", 64'({oDE, oSOF, oSOL, oLOCKED, oERR}), 64'd0);
          check("rst_async_pix", 64'({oX, oY, oDATA}), 64'd0);
          check("rst_async_geom", 64'({oH_TOTAL, oH_ACTIVE, oV_TOTAL, oV_ACTIVE}), 64'd0);
          check("rst_async_state", 64'(dbg_state), 64'd0);
        end
        if (ln == rst_line && c == 11) begin
          #1 iRST = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int v, vs4, vs6, n;
    iRST = 1'b1; iDE = 1'b0; iHS = 1'b0; iVS = 1'b0; iDATA = '0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #2;
    check("reset_ctl", 64'({oDE, oSOF, oSOL, oLOCKED, oERR}), 64'd0);
    check("reset_pix", 64'({oX, oY, oDATA}), 64'd0);
    check("reset_geom", 64'({oH_TOTAL, oH_ACTIVE, oV_TOTAL, oV_ACTIVE}), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1 iRST = 1'b0;
    repeat (5) drive(1'b0, 1'b0, 1'b0, 24'd0);

    // Acquisition from reset: lock at VS edge starting frame 4
    for (int f = 0; f < 3; f++) run_frame(-1, 1'b0, -1, v);
    check("lock_early", 64'(oLOCKED), 64'd0);
    run_frame(-1, 1'b1, -1, vs4);
    check("lock_f4", 64'(oLOCKED), 64'd1);
    check("geom_f4", 64'({oH_TOTAL, oH_ACTIVE, oV_TOTAL, oV_ACTIVE}), 64'(GEOM));
    check("lock_latency", 64'(lock_rise_cyc - vs4), 64'd2);
    check("state_locked", 64'(dbg_state), 64'd2);

    // One 21-clock line: error at next VS edge, geometry holds, relock after 2 frames
    run_frame(5, 1'b1, -1, v);
    run_frame(-1, 1'b0, -1, vs6);
    check("err_count_1", 64'(err_cnt), 64'd1);
    check("err_latency", 64'(err_cyc - vs6), 64'd2);
    check("unlocked_after_err", 64'(oLOCKED), 64'd0);
    check("geom_hold", 64'({oH_TOTAL, oH_ACTIVE, oV_TOTAL, oV_ACTIVE}), 64'(GEOM));
    run_frame(-1, 1'b0, -1, v);
    check("relock_early", 64'(oLOCKED), 64'd0);
    run_frame(-1, 1'b1, -1, v);
    check("relock", 64'(oLOCKED), 64'd1);

    // HS absent long enough to saturate the line counter
    n = 0;
    while (err_cnt < 2 && n < 4400) begin
      drive(1'b0, 1'b0, 1'b0, 24'd0);
      n++;
    end
    check("sat_err", 64'(err_cnt), 64'd2);
    check("sat_timing", 64'(n >= 4060 && n <= 4100), 64'd1);
    check("sat_unlocked", 64'(oLOCKED), 64'd0);
    check("sat_state", 64'(dbg_state), 64'd0);

    // Reacquire, then reset mid-line while locked
    for (int f = 0; f < 3; f++) run_frame(-1, 1'b0, -1, v);
    run_frame(-1, 1'b1, 4, v);
    check("err_count_rst", 64'(err_cnt), 64'd2);
    for (int f = 0; f < 3; f++) run_frame(-1, 1'b0, -1, v);
    check("rst_relock_early", 64'(oLOCKED), 64'd0);
    run_frame(-1, 1'b1, -1, v);
    check("rst_relock", 64'(oLOCKED), 64'd1);
    check("rst_geom", 64'({oH_TOTAL, oH_ACTIVE, oV_TOTAL, oV_ACTIVE}), 64'(GEOM));

    repeat (10) drive(1'b0, 1'b0, 1'b0, 24'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
